ic_gb8_block_store: RTL and testbench

Double-buffered 8x8 RGB block store. It sits directly downstream of the 8x8 block address generator and its line buffer. It accepts the 48 packed 32-bit words of one 8x8x3 block as the buffer RAM returns them, unpacks them into 64 RGB pixels, and streams the pixels in raster order to the colour-conversion/DCT stage through a ready/valid handshake. Two banks let one block be received while the previous one drains.

---
 rtl/ic_gb8_pkg.sv | 46 ++++
 rtl/ic_gb8_block_bank.sv | 40 ++++
 rtl/ic_gb8_block_store.sv | 197 +++++++++++++++++++
 tb/tb_ic_gb8_block_store.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ic_gb8_pkg.sv
// Shared geometry, byte-lane mapping and read-state type for the 8x8 RGB block store.
package ic_gb8_pkg;

  localparam int WORDS_PER_ROW    = 6;
  localparam int WORDS_PER_BLOCK  = 48;
  localparam int PIXELS_PER_BLOCK = 64;

  typedef enum logic [1:0] {
    COMP_R = 2'd0,
    COMP_G = 2'd1,
    COMP_B = 2'd2
  } comp_e;

  // to_hi selects the second pixel a word touches (base+phase+1) instead of the first.
  typedef struct packed {
    logic  to_hi;
    comp_e comp;
  } lane_map_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  function automatic lane_map_t lane_map(input logic [1:0] phase, input logic [1:0] lane);
    lane_map_t m;
    m = '{to_hi: 1'b0, comp: COMP_R};
    case ({phase, lane})
      4'b00_00: m = '{to_hi: 1'b0, comp: COMP_R};
      4'b00_01: m = '{to_hi: 1'b0, comp: COMP_G};
      4'b00_10: m = '{to_hi: 1'b0, comp: COMP_B};
      4'b00_11: m = '{to_hi: 1'b1, comp: COMP_R};
      4'b01_00: m = '{to_hi: 1'b0, comp: COMP_G};
      4'b01_01: m = '{to_hi: 1'b0, comp: COMP_B};
      4'b01_10: m = '{to_hi: 1'b1, comp: COMP_R};
      4'b01_11: m = '{to_hi: 1'b1, comp: COMP_G};
      4'b10_00: m = '{to_hi: 1'b0, comp: COMP_B};
      4'b10_01: m = '{to_hi: 1'b1, comp: COMP_R};
      4'b10_10: m = '{to_hi: 1'b1, comp: COMP_G};
      4'b10_11: m = '{to_hi: 1'b1, comp: COMP_B};
      default:  m = '{to_hi: 1'b0, comp: COMP_R};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ic_gb8_block_bank.sv
// One 64-entry RGB pixel bank: two component-masked write ports, one registered read port.
module ic_gb8_block_bank
  import ic_gb8_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wa_en,
  input  logic [5:0]  wa_addr,
  input  logic [2:0]  wa_comp_en,
  input  logic [23:0] wa_data,
  input  logic        wb_en,
  input  logic [5:0]  wb_addr,
  input  logic [2:0]  wb_comp_en,
  input  logic [23:0] wb_data,
  input  logic        rd_en,
  input  logic [5:0]  rd_addr,
  output logic [23:0] rd_data
);

  logic [23:0] mem_q [PIXELS_PER_BLOCK];
  logic [23:0] rd_data_q, rd_data_d;

  // NOTE: the storage array has no reset; every entry is written before the reader may reach it.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (wa_en && wa_comp_en[c]) mem_q[wa_addr][8*c +: 8] <= wa_data[8*c +: 8];
      if (wb_en && wb_comp_en[c]) mem_q[wb_addr][8*c +: 8] <= wb_data[8*c +: 8];
    end
  end

  assign rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ic_gb8_block_store.sv
// Double-buffered 8x8 RGB block store: unpacks 48 packed words per block into a bank,
// then streams 64 pixels in raster order through a ready/valid output.
module ic_gb8_block_store
  import ic_gb8_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic [2:0]  out_row,
  output logic [2:0]  out_col,
  output logic        out_sob,
  output logic        out_eob,
  output logic        overflow
);

  logic [2:0]  wrow_q, wrow_d, wword_q, wword_d;
  logic        wbank_q, wbank_d, overflow_q, overflow_d;
  logic [1:0]  full_q, full_d, full_set, full_clr;
  logic        wr_accept, wr_group;
  logic [1:0]  wr_phase;
  logic [5:0]  wa_addr, wb_addr;
  logic [2:0]  wa_comp_en, wb_comp_en;
  logic [23:0] wa_data, wb_data;
  lane_map_t   lane;

  rd_state_e   state_q, state_d;
  logic [5:0]  rcnt_q, rcnt_d, rd_addr;
  logic        rbank_q, rbank_d, out_bank_q, out_bank_d;
  logic        rd_load, rd_sel;
  logic [23:0] rd_data0, rd_data1, pix;

  // Word counter kept as row/word-in-row; a block ends on row 7, word 5.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    wrow_d     = wrow_q;
    wword_d    = wword_q;
    wbank_d    = wbank_q;
    overflow_d = overflow_q;
    full_set   = '0;
    wr_accept  = in_valid && !full_q[wbank_q];
    if (in_valid && full_q[wbank_q]) overflow_d = 1'b1;
    if (wr_accept) begin
      if (wword_q == 3'(WORDS_PER_ROW - 1)) begin
        wword_d = '0;
        wrow_d  = wrow_q + 3'd1;
        if (wrow_q == 3'd7) begin
          full_set[wbank_q] = 1'b1;
          wbank_d           = ~wbank_q;
        end
      end else begin
        wword_d = wword_q + 3'd1;
      end
    end
  end

  always_comb begin
    wr_group   = (wword_q >= 3'd3);
    wr_phase   = wr_group ? 2'(wword_q - 3'd3) : wword_q[1:0];
    wa_addr    = {wrow_q, wr_group, 2'b00} + {4'd0, wr_phase};
    wb_addr    = wa_addr + 6'd1;
    wa_comp_en = '0;
    wb_comp_en = '0;
    wa_data    = '0;
    wb_data    = '0;
    lane       = '0;
    for (int l = 0; l < 4; l++) begin
      lane = lane_map(wr_phase, 2'(l));
      if (lane.to_hi) begin
        wb_comp_en[lane.comp]    = 1'b1;
        wb_data[8*lane.comp +: 8] = in_data[8*l +: 8];
      end else begin
        wa_comp_en[lane.comp]    = 1'b1;
        wa_data[8*lane.comp +: 8] = in_data[8*l +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    rbank_d    = rbank_q;
    out_bank_d = out_bank_q;
    full_clr   = '0;
    rd_load    = 1'b0;
    rd_sel     = rbank_q;
    rd_addr    = '0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rbank_q]) begin
          rd_load    = 1'b1;
          rcnt_d     = '0;
          out_bank_d = rbank_q;
          state_d    = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (out_ready) begin
          if (rcnt_q == 6'(PIXELS_PER_BLOCK - 1)) begin
            full_clr[rbank_q] = 1'b1;
            rbank_d           = ~rbank_q;
            rcnt_d            = '0;
            // Chain straight into the other bank when it is already waiting.
            if (full_q[~rbank_q]) begin
              rd_load    = 1'b1;
              rd_sel     = ~rbank_q;
              out_bank_d = ~rbank_q;
            end else begin
              state_d = RD_IDLE;
            end
          end else begin
            rcnt_d  = rcnt_q + 6'd1;
            rd_load = 1'b1;
            rd_addr = rcnt_q + 6'd1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign full_d = (full_q | full_set) & ~full_clr;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      wrow_q     <= '0;
      wword_q    <= '0;
      wbank_q    <= 1'b0;
      overflow_q <= 1'b0;
      full_q     <= '0;
      state_q    <= RD_IDLE;
      rcnt_q     <= '0;
      rbank_q    <= 1'b0;
      out_bank_q <= 1'b0;
    end else begin
      wrow_q     <= wrow_d;
      wword_q    <= wword_d;
      wbank_q    <= wbank_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      rbank_q    <= rbank_d;
      out_bank_q <= out_bank_d;
    end
  end

  ic_gb8_block_bank u_bank0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .wa_en      (wr_accept && !wbank_q),
    .wa_addr    (wa_addr),
    .wa_comp_en (wa_comp_en),
    .wa_data    (wa_data),
    .wb_en      (wr_accept && !wbank_q),
    .wb_addr    (wb_addr),
    .wb_comp_en (wb_comp_en),
    .wb_data    (wb_data),
    .rd_en      (rd_load && !rd_sel),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data0)
  );

  ic_gb8_block_bank u_bank1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .wa_en      (wr_accept && wbank_q),
    .wa_addr    (wa_addr),
    .wa_comp_en (wa_comp_en),
    .wa_data    (wa_data),
    .wb_en      (wr_accept && wbank_q),
    .wb_addr    (wb_addr),
    .wb_comp_en (wb_comp_en),
    .wb_data    (wb_data),
    .rd_en      (rd_load && rd_sel),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data1)
  );

  assign pix       = out_bank_q ? rd_data1 : rd_data0;
  assign out_r     = pix[8*COMP_R +: 8];
  assign out_g     = pix[8*COMP_G +: 8];
  assign out_b     = pix[8*COMP_B +: 8];
  assign out_valid = (state_q == RD_STREAM);
  assign out_row   = rcnt_q[5:3];
  assign out_col   = rcnt_q[2:0];
  assign out_sob   = out_valid && (rcnt_q == 6'd0);
  assign out_eob   = out_valid && (rcnt_q == 6'(PIXELS_PER_BLOCK - 1));
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ic_gb8_block_store.sv
// Directed bench for ic_gb8_block_store: expected pixels are queued as blocks are sent
// and popped on each output handshake.
module tb_ic_gb8_block_store;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_sob, out_eob, overflow;
  logic [7:0]  out_r, out_g, out_b;
  logic [2:0]  out_row, out_col;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] obs_pix;
  logic [31:0] prev_pix = '0;
  logic        prev_stall = 1'b0;
  bit          watch = 1'b0;
  bit          seen_valid = 1'b0;
  int          bubble_cnt = 0;

  ic_gb8_block_store dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign obs_pix = {out_r, out_g, out_b, out_row, out_col, out_sob, out_eob};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] blk_byte(input int off, input int k);
    return 8'(off + k);
  endfunction

  // Raster pixel n of a block is stream bytes 3n..3n+2 as R,G,B.
  function automatic logic [31:0] exp_pixel(input int off, input int n);
    return {blk_byte(off, 3*n), blk_byte(off, 3*n+1), blk_byte(off, 3*n+2),
            3'(n / 8), 3'(n % 8), (n == 0), (n == 63)};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_pix", obs_pix, prev_pix);
        check("hold_valid", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
        else                   check("pixel", obs_pix, exp_q.pop_front());
      end
      if (watch && out_valid) seen_valid = 1'b1;
      if (watch && seen_valid && !out_valid && exp_q.size() != 0) bubble_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_pix   = obs_pix;
    end
  end

  task automatic send_block(input int off, input int nwords, input bit push,
                            input bit gaps, input bit rand_ready);
    int g;
    if (push) for (int n = 0; n < 64; n++) exp_q.push_back(exp_pixel(off, n));
    for (int w = 0; w < nwords; w++) begin
      in_data  = {blk_byte(off, 4*w+3), blk_byte(off, 4*w+2),
                  blk_byte(off, 4*w+1), blk_byte(off, 4*w)};
      in_valid = 1'b1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, 5);
        repeat (g) begin
          if (rand_ready) out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic drain(input bit rand_ready, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      i++;
    end
    out_ready = 1'b1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix", obs_pix, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    // Single block with sequential bytes and first-pixel latency.
    send_block(0, 48, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_first", 32'(out_valid), 32'd1);
    check("lat_sob", 32'(out_sob), 32'd1);
    drain(1'b0, 200);

    // Random backpressure over two blocks.
    send_block(30, 48, 1'b1, 1'b0, 1'b1);
    send_block(60, 48, 1'b1, 1'b0, 1'b1);
    drain(1'b1, 2000);

    // Three blocks; the third waits until the first bank has drained, yet arrives
    // before the second bank finishes, so the stream must stay bubble-free.
    watch = 1'b1; seen_valid = 1'b0; bubble_cnt = 0;
    send_block(90, 48, 1'b1, 1'b0, 1'b0);
    send_block(120, 48, 1'b1, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    send_block(150, 48, 1'b1, 1'b0, 1'b0);
    drain(1'b0, 500);
    watch = 1'b0;
    check("b2b_bubbles", 32'(bubble_cnt), 32'd0);
    check("b2b_overflow", 32'(overflow), 32'd0);

    // Gapped input.
    send_block(0, 48, 1'b1, 1'b1, 1'b0);
    drain(1'b0, 500);

    // Overflow: third block dropped while the consumer is stalled.
    out_ready = 1'b0;
    send_block(200, 48, 1'b1, 1'b0, 1'b0);
    send_block(17, 48, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_before", 32'(overflow), 32'd0);
    send_block(77, 48, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    drain(1'b0, 500);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset after a partial block, then a clean block.
    send_block(5, 20, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    send_block(33, 48, 1'b1, 1'b0, 1'b0);
    drain(1'b0, 500);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
